// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared types and constants for the register-file op sequencer.
// Op codes, FSM state encoding and datapath widths.
package rf_seq_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational ALU for the op sequencer.
// Signed overflow is flagged for ADD/SUB only; op 7 reports illegal.
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [REG_DW-1:0] a,
  input  logic [REG_DW-1:0] b,
  output logic [REG_DW-1:0] result,
  output logic              ovf,
  output logic              illegal
);

  logic [REG_DW-1:0] sum;
  logic [REG_DW-1:0] diff;
  logic              lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  // Select the result and flags for the requested op.
  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[REG_DW-1] == b[REG_DW-1]) &&
                 (sum[REG_DW-1] != a[REG_DW-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[REG_DW-1] != b[REG_DW-1]) &&
                 (diff[REG_DW-1] != a[REG_DW-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SLT: result = {{(REG_DW-1){1'b0}}, lt};
      OP_ILL: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: one-at-a-time read/execute/writeback command engine.
// Optional RF_SEQ_ZERO_GUARD_EN suppresses writes to register 0.
module rf_op_sequencer
  import rf_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [REG_AW-1:0] cmd_rd,
  output logic              done,
  output logic              err,
  output logic [REG_DW-1:0] result,
  output logic              ovf,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_addr_r1,
  output logic [REG_AW-1:0] rf_addr_r2,
  output logic [REG_AW-1:0] rf_addr_w,
  output logic [REG_DW-1:0] rf_data_w,
  input  logic [REG_DW-1:0] rf_data_r1,
  input  logic [REG_DW-1:0] rf_data_r2
);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_DW-1:0] a_q;
  logic [REG_DW-1:0] b_q;
  logic [REG_DW-1:0] alu_res;
  logic              alu_ovf;
  logic              alu_ill;
  logic              zero_block;
  logic              in_exec;

  assign accept  = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign in_exec = (state_q == EXEC);

`ifdef RF_SEQ_ZERO_GUARD_EN
  assign zero_block = (rd_q == '0);
`else
  assign zero_block = 1'b0;
`endif

  rf_seq_alu u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .result  (alu_res),
    .ovf     (alu_ovf),
    .illegal (alu_ill)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed four-step walk once a command is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = READ;
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered so it only rises one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_ready <= 1'b0;
    else        cmd_ready <= (state_d == IDLE);
  end

  // Latch the command; read addresses are live through READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      rd_q       <= '0;
      rf_addr_r1 <= '0;
      rf_addr_r2 <= '0;
    end else if (accept) begin
      op_q       <= cmd_op;
      rd_q       <= cmd_rd;
      rf_addr_r1 <= cmd_rs;
      rf_addr_r2 <= cmd_rt;
    end
  end

  // Capture operands at the end of READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == READ) begin
      a_q <= rf_data_r1;
      b_q <= rf_data_r2;
    end
  end

  // Register EXEC results; these drive the WB cycle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      rf_wen    <= 1'b0;
      result    <= '0;
      rf_addr_w <= '0;
      rf_data_w <= '0;
    end else begin
      done   <= in_exec;
      err    <= in_exec && alu_ill;
      rf_wen <= in_exec && !alu_ill && !zero_block;
      if (in_exec) begin
        ovf       <= alu_ovf;
        rf_addr_w <= rd_q;
        if (!alu_ill) begin
          result    <= alu_res;
          rf_data_w <= alu_res;
        end
      end
    end
  end

endmodule

// File: doc/rf_op_sequencer.md
# rf_op_sequencer

Command-driven initiator for the 32x32 register file: accepts one register-to-register ALU command at a time, reads the two source registers, computes the result and writes it back. It sits between a simple command source (testbench, debug port or future decode stage) and the register file's read/write ports. It exercises the register file's timing: combinational reads, and writes sampled on the falling clock edge.

## Interface
Parameters
- none; widths are fixed at 5-bit addresses and 32-bit data.

Ports
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  operation code.
- cmd_rs  in  5  source register 1.
- cmd_rt  in  5  source register 2.
- cmd_rd  in  5  destination register.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: illegal op, no write performed.
- result  out  32  computed value; valid with done, held until the next done.
- ovf  out  1  signed overflow for ADD/SUB; valid with done.
- rf_wen  out  1  register-file write enable.
- rf_addr_r1  out  5  read address 1.
- rf_addr_r2  out  5  read address 2.
- rf_addr_w  out  5  write address.
- rf_data_w  out  32  write data.
- rf_data_r1  in  32  read data 1 (combinational from rf_addr_r1).
- rf_data_r2  in  32  read data 2.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 1 or 0), 7 illegal.
- Arithmetic is modulo 2^32. ovf = signed overflow of ADD/SUB only; ovf = 0 for all other ops.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch op/rs/rt/rd and go to READ.
  - READ: drive rf_addr_r1 = rs and rf_addr_r2 = rt; capture rf_data_r1/r2 at posedge; go to EXEC.
  - EXEC: compute; register result/ovf; go to WB.
  - WB: rf_wen = 1 (unless op is illegal or suppressed), rf_addr_w = rd, rf_data_w = result; done = 1; go to IDLE.
- Illegal op: full sequence runs; in WB, rf_wen = 0, err = 1, result unchanged.
- rs/rt equal to rd, or equal to each other, are legal; reads always observe values written by earlier commands.
- cmd_* is ignored when cmd_ready = 0.

## Timing
- Reset values: cmd_ready = 0, done = 0, err = 0, ovf = 0, result = 0, rf_wen = 0, all rf_addr_* = 0, rf_data_w = 0, state = IDLE.
- cmd_ready is registered and rises at the first posedge after rst_n deasserts.
- Handshake at posedge T → READ in T+1, EXEC in T+2, WB/done in T+3, IDLE (ready) in T+4.
- Throughput is one command per 4 cycles. A back-to-back command can be accepted at T+4.
- The register file samples the write at the negedge inside the WB cycle, so the next command's READ (at T+5 or later) sees the new value. No forwarding is needed.
- rf_addr_r*/rf_addr_w/rf_data_w hold their last values outside their active state. rf_wen is high only in WB.
- rst_n asserted mid-command: rf_wen drops immediately (asynchronously). The command is discarded with no write and no done, and the sequencer returns to IDLE.

## Configuration
- RF_SEQ_ZERO_GUARD_EN defined: a command with rd = 0 runs normally but rf_wen stays 0 in WB. done pulses; result and ovf are reported; err = 0.
- RF_SEQ_ZERO_GUARD_EN undefined: rd = 0 is written like any other register.

## Structure
- Package rf_seq_pkg holds:
  - op code constants (OP_ADD … OP_ILL);
  - the state enum (IDLE, READ, EXEC, WB);
  - width constants (REG_AW = 5, REG_DW = 32).
- Sub-module rf_seq_alu: combinational; op, a, b → result, ovf, illegal.
- Top-level rf_op_sequencer contains the FSM and registers.

## Test plan
- Reset release → cmd_ready = 0 in the first cycle, 1 in the next; all other outputs 0; no rf_wen.
- Behavioral regfile with r1 = 5, r2 = 7. Command ADD rs=1 rt=2 rd=3 → done at T+3, result = 12, r3 = 12 after the WB negedge.
- r1 = 0x7FFFFFFF, r2 = 1, ADD → result = 0x80000000, ovf = 1. Then SLT r3, r1 with r3 = 0x80000000 → result = 1.
- Back-to-back: ADD r4 = r1 + r2, then accepted at T+4 SUB r5 = r4 − r1 → r5 reads the updated r4. With r1 = 5, r2 = 7: r4 = 12, r5 = 7.
- op = 7 → done = 1, err = 1, rf_wen never asserted, result unchanged. rd = 0 with the macro defined → no write; without the macro → r0 written.
- rst_n pulsed low during EXEC → rf_wen stays 0, no done. After release, a new command completes normally.
